// File: rtl/rx_fsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rx_fsm_pkg
//  Description : Shared definitions for the UART receiver control FSM.
//                - Frame state encodings: 3-bit binary.
//                - Minimum usable oversampling ratio.
//                - Position of the check strobes relative to mid-bit.
//  Revision    : 1.0  initial release
// ============================================================================
package rx_fsm_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // Any prescale below this is raised to it, which keeps H+3 <= P-1.
    localparam int PRESCALE_MIN = 8;

    // The sampler votes on ticks H-1..H+1 and registers its result, so the
    // checkers may consume it at tick H+2.
    localparam int VOTE_OFFSET  = 2;

endpackage : rx_fsm_pkg
`default_nettype wire

// File: rtl/rx_fsm_edge_bit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : edge_bit_counter
//  Description : Oversample tick counter and bit counter for the UART RX FSM.
//                edge_cnt runs 0..last_edge and wraps. Each wrap advances
//                bit_cnt by one.
//  Ports       : clk_i        clock
//                rst_i        synchronous active-high reset
//                clr_i        clear both counters to 0
//                load_i       start a frame: edge_cnt=1, bit_cnt=0
//                en_i         count one tick
//                last_edge_i  P-1, the final tick of a bit
//                edge_cnt_o   tick index within the bit
//                bit_cnt_o    bit index within the frame
//                bit_end_o    edge_cnt_o == last_edge_i
//  Revision    : 1.0  initial release
// ============================================================================
module edge_bit_counter #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  load_i,
    input  logic                  en_i,
    input  logic [PRESCALE_W-1:0] last_edge_i,
    output logic [PRESCALE_W-1:0] edge_cnt_o,
    output logic [BIT_CNT_W-1:0]  bit_cnt_o,
    output logic                  bit_end_o
);

    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;

    assign bit_end_o = (edge_cnt_q == last_edge_i);

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        if (clr_i) begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
        end else if (load_i) begin
            // The start-detect cycle itself is tick 0.
            edge_cnt_d = PRESCALE_W'(1);
            bit_cnt_d  = '0;
        end else if (en_i) begin
            if (bit_end_o) begin
                edge_cnt_d = '0;
                bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
            end else begin
                edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign edge_cnt_o = edge_cnt_q;
    assign bit_cnt_o  = bit_cnt_q;

endmodule : edge_bit_counter
`default_nettype wire

// File: rtl/rx_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : rx_fsm
//  Description : UART receiver control FSM. Sequences START, DATA, optional
//                PARITY and STOP bits, pulses the per-bit check strobes at
//                tick H+2, and reports an accepted frame on data_valid.
//  Ports       : rx_fsm_clk   oversampling clock
//                rx_fsm_rst   synchronous active-high reset
//                rx_in        serial line, idle high
//                prescale     oversampling ratio (values < 8 act as 8)
//                par_en       parity bit present
//                strt_glitch  start checker result
//                par_err      parity checker result
//                stp_err      stop checker result
//                edge_cnt     tick index within the bit
//                bit_cnt      bit index within the frame (start = 0)
//                dat_samp_en  sampler enable, high outside IDLE
//                deser_en     shift strobe (DATA)
//                strt_chk_en  start check strobe
//                par_chk_en   parity check strobe
//                stp_chk_en   stop check strobe
//                data_valid   one-cycle pulse, frame accepted
//                frame_err    (RX_FSM_ERR_FLAGS_EN) frame rejected pulse
//                glitch_abort (RX_FSM_ERR_FLAGS_EN) start glitch abort pulse
//  Options     : `define RX_FSM_ERR_FLAGS_EN adds frame_err / glitch_abort.
//  Revision    : 1.0  initial release
// ============================================================================
module rx_fsm
    import rx_fsm_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  rx_fsm_clk,
    input  logic                  rx_fsm_rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  strt_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  dat_samp_en,
    output logic                  deser_en,
    output logic                  strt_chk_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  data_valid
`ifdef RX_FSM_ERR_FLAGS_EN
    ,
    output logic                  frame_err,
    output logic                  glitch_abort
`endif
);

    localparam logic [PRESCALE_W-1:0] c_prescale_min = PRESCALE_W'(PRESCALE_MIN);
    localparam logic [PRESCALE_W-1:0] c_vote_offset  = PRESCALE_W'(VOTE_OFFSET);
    localparam logic [BIT_CNT_W-1:0]  c_last_data    = BIT_CNT_W'(DATA_WIDTH);

    rx_state_e             state_q,      state_d;
    logic [PRESCALE_W-1:0] prescale_q,   prescale_d;
    logic                  par_flag_q,   par_flag_d;
    logic                  data_valid_q, data_valid_d;
`ifdef RX_FSM_ERR_FLAGS_EN
    logic                  frame_err_q,    frame_err_d;
    logic                  glitch_abort_q, glitch_abort_d;
`endif

    logic                  w_cnt_clr;
    logic                  w_cnt_load;
    logic                  w_cnt_en;
    logic                  w_bit_end;
    logic                  w_strb_hit;
    logic [PRESCALE_W-1:0] w_last_edge;
    logic [PRESCALE_W-1:0] w_strb_edge;

    // Timing derives only from the prescale latched at start detect, so a
    // prescale change mid-frame cannot disturb the current frame.
    assign w_last_edge = prescale_q - PRESCALE_W'(1);
    assign w_strb_edge = (prescale_q >> 1) + c_vote_offset;
    assign w_strb_hit  = (edge_cnt == w_strb_edge);

    edge_bit_counter #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_CNT_W  (BIT_CNT_W)
    ) u_cnt (
        .clk_i       (rx_fsm_clk),
        .rst_i       (rx_fsm_rst),
        .clr_i       (w_cnt_clr),
        .load_i      (w_cnt_load),
        .en_i        (w_cnt_en),
        .last_edge_i (w_last_edge),
        .edge_cnt_o  (edge_cnt),
        .bit_cnt_o   (bit_cnt),
        .bit_end_o   (w_bit_end)
    );

    always_comb begin
        state_d        = state_q;
        prescale_d     = prescale_q;
        par_flag_d     = par_flag_q;
        data_valid_d   = 1'b0;
`ifdef RX_FSM_ERR_FLAGS_EN
        frame_err_d    = 1'b0;
        glitch_abort_d = 1'b0;
`endif
        w_cnt_clr      = 1'b0;
        w_cnt_load     = 1'b0;
        w_cnt_en       = 1'b0;
        dat_samp_en    = (state_q != IDLE);
        deser_en       = 1'b0;
        strt_chk_en    = 1'b0;
        par_chk_en     = 1'b0;
        stp_chk_en     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_in) begin
                    state_d    = START;
                    w_cnt_load = 1'b1;
                    par_flag_d = 1'b0;
                    prescale_d = (prescale < c_prescale_min) ? c_prescale_min : prescale;
                end
            end
            START: begin
                w_cnt_en    = 1'b1;
                strt_chk_en = w_strb_hit;
                if (w_bit_end) begin
                    if (strt_glitch) begin
                        state_d   = IDLE;
                        w_cnt_clr = 1'b1;
`ifdef RX_FSM_ERR_FLAGS_EN
                        glitch_abort_d = 1'b1;
`endif
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                w_cnt_en = 1'b1;
                deser_en = w_strb_hit;
                // par_en only matters here, at the end of the last data bit.
                if (w_bit_end && (bit_cnt == c_last_data)) begin
                    state_d = par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                w_cnt_en   = 1'b1;
                par_chk_en = w_strb_hit;
                if (w_bit_end) begin
                    par_flag_d = par_err;
                    state_d    = STOP;
                end
            end
            STOP: begin
                w_cnt_en   = 1'b1;
                stp_chk_en = w_strb_hit;
                if (w_bit_end) begin
                    // Clearing here lets IDLE sample rx_in on the very next
                    // cycle, so a back-to-back start bit is not missed.
                    state_d   = IDLE;
                    w_cnt_clr = 1'b1;
                    if (!stp_err && !par_flag_q) begin
                        data_valid_d = 1'b1;
                    end else begin
`ifdef RX_FSM_ERR_FLAGS_EN
                        frame_err_d = 1'b1;
`endif
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                w_cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge rx_fsm_clk) begin
        if (rx_fsm_rst) begin
            state_q        <= IDLE;
            prescale_q     <= c_prescale_min;
            par_flag_q     <= 1'b0;
            data_valid_q   <= 1'b0;
`ifdef RX_FSM_ERR_FLAGS_EN
            frame_err_q    <= 1'b0;
            glitch_abort_q <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            prescale_q     <= prescale_d;
            par_flag_q     <= par_flag_d;
            data_valid_q   <= data_valid_d;
`ifdef RX_FSM_ERR_FLAGS_EN
            frame_err_q    <= frame_err_d;
            glitch_abort_q <= glitch_abort_d;
`endif
        end
    end

    assign data_valid   = data_valid_q;
`ifdef RX_FSM_ERR_FLAGS_EN
    assign frame_err    = frame_err_q;
    assign glitch_abort = glitch_abort_q;
`endif

endmodule : rx_fsm
`default_nettype wire
